// File: rtl/minmax_window_tracker_if.sv
// Bus bundle for the min/max window tracker: the sample input stream, the
// window result output stream and a debug view of the FSM state.
//
// Handshake rule (both streams): the producer raises valid and holds it, with
// its data stable, until the consumer's ready is high on a rising edge. A
// transfer happens on every edge where valid && ready. A producer never drops
// valid before that transfer, and ready may be driven combinationally.
interface minmax_window_tracker_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_min;
  logic [DATA_W-1:0] out_max;
  logic [DATA_W-1:0] out_range;
  logic [CNT_W-1:0]  out_count;
  logic              fsm_state;  // 0 = ACCUM, 1 = HOLD

  // The environment side: it drives samples, flush and result acceptance.
  modport master (
    output in_valid, in_data, flush, out_ready,
    input  in_ready, out_valid, out_min, out_max, out_range, out_count, fsm_state
  );

  // The tracker side.
  modport slave (
    input  in_valid, in_data, flush, out_ready,
    output in_ready, out_valid, out_min, out_max, out_range, out_count, fsm_state
  );
endinterface

// File: rtl/minmax_window_tracker.sv
// Tracks the running unsigned min/max of a sample stream over windows of
// WINDOW_LEN samples (or fewer when flushed) and holds the window summary
// on the output stream until it is taken.
module minmax_window_tracker #(
  parameter int DATA_W     = 8,
  parameter int WINDOW_LEN = 16,
  parameter int CNT_W      = $clog2(WINDOW_LEN + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  minmax_window_tracker_if.slave bus
);

  typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

  state_t            state;
  logic [CNT_W-1:0]  count;
  logic [DATA_W-1:0] cur_min;
  logic [DATA_W-1:0] cur_max;

  logic              out_valid_q;
  logic [DATA_W-1:0] out_min_q;
  logic [DATA_W-1:0] out_max_q;
  logic [DATA_W-1:0] out_range_q;
  logic [CNT_W-1:0]  out_count_q;

  logic              accept;
  logic              close;
  logic [CNT_W-1:0]  nxt_count;
  logic [DATA_W-1:0] nxt_min;
  logic [DATA_W-1:0] nxt_max;

  // Samples are only taken while accumulating and out of reset.
  assign bus.in_ready  = rst_n && (state == ACCUM);
  assign accept        = bus.in_valid && bus.in_ready;

  assign bus.out_valid = out_valid_q;
  assign bus.out_min   = out_min_q;
  assign bus.out_max   = out_max_q;
  assign bus.out_range = out_range_q;
  assign bus.out_count = out_count_q;
  assign bus.fsm_state = state;

  // Post-update window statistics, including this cycle's sample if taken;
  // the close decision and the registered result both use these.
  always_comb begin
    nxt_min   = cur_min;
    nxt_max   = cur_max;
    nxt_count = count;
    if (accept) begin
      nxt_count = count + CNT_W'(1);
      if (count == '0) begin
        nxt_min = bus.in_data;
        nxt_max = bus.in_data;
      end else begin
        // Strict compares so a tie keeps the stored value.
        if (bus.in_data < cur_min) nxt_min = bus.in_data;
        if (bus.in_data > cur_max) nxt_max = bus.in_data;
      end
    end
    close = (state == ACCUM) &&
            ((accept && (nxt_count == CNT_W'(WINDOW_LEN))) ||
             (bus.flush && (nxt_count != '0)));
  end

  // Window FSM: accumulate, then hold the result until it is accepted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ACCUM;
      count       <= '0;
      cur_min     <= '0;
      cur_max     <= '0;
      out_valid_q <= 1'b0;
      out_min_q   <= '0;
      out_max_q   <= '0;
      out_range_q <= '0;
      out_count_q <= '0;
    end else begin
      case (state)
        ACCUM: begin
          count   <= nxt_count;
          cur_min <= nxt_min;
          cur_max <= nxt_max;
          if (close) begin
            out_min_q   <= nxt_min;
            out_max_q   <= nxt_max;
            // nxt_max >= nxt_min always holds, so this never wraps.
            out_range_q <= nxt_max - nxt_min;
            out_count_q <= nxt_count;
            out_valid_q <= 1'b1;
            state       <= HOLD;
          end
        end
        HOLD: begin
          // Result registers keep their values after the handshake.
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            count       <= '0;
            state       <= ACCUM;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule
